// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per SHIFT/CHECK pair.
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIX cycle).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SHIFT, S_CHECK, S_FIX, S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic             zero_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
`ifdef DIV_SIGNED_EN
  logic             neg_quo_q;
  logic             neg_rem_q;
`endif

  logic             ge;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  always_comb begin
    ge    = rem_q >= {1'b0, dvs_q};
    rem_d = ge ? rem_q - {1'b0, dvs_q} : rem_q;
    quo_d = {quo_q[WIDTH-1:1], ge};
`ifdef DIV_SIGNED_EN
    dvd_mag = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
    dvs_mag = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
`else
    dvd_mag = dvd_q;
    dvs_mag = dvs_q;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            dvd_q   <= i_dividend;
            dvs_q   <= i_divisor;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          rem_q  <= '0;
          quo_q  <= dvd_mag;
          dvs_q  <= dvs_mag;
          zero_q <= (dvs_q == '0);
`ifdef DIV_SIGNED_EN
          neg_quo_q <= dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
          neg_rem_q <= dvd_q[WIDTH-1];
`endif
          // zero divisor takes one CHECK pass that only posts the fixed result
          if (dvs_q == '0) begin
            cnt_q   <= '0;
            state_q <= S_CHECK;
          end else begin
            cnt_q   <= CW'(WIDTH);
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          rem_q   <= {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
          quo_q   <= {quo_q[WIDTH-2:0], 1'b0};
          cnt_q   <= cnt_q - 1'b1;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (zero_q) begin
            q_q     <= '1;
            r_q     <= dvd_q;
            dbz_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q != '0) begin
              state_q <= S_SHIFT;
            end else begin
`ifdef DIV_SIGNED_EN
              state_q <= S_FIX;
`else
              q_q     <= quo_d;
              r_q     <= rem_d[WIDTH-1:0];
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
`endif
            end
          end
        end
`ifdef DIV_SIGNED_EN
        S_FIX: begin
          q_q     <= neg_quo_q ? -quo_q : quo_q;
          r_q     <= neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_quotient    = q_q;
  assign o_remainder   = r_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8).
// Expected results follow DIV_SIGNED_EN when it is defined.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dvd;
  logic [W-1:0] dvs;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         dbz;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_dividend    (dvd),
    .i_divisor     (dvs),
    .o_quotient    (q),
    .o_remainder   (r),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_by_zero (dbz)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, int t0);
    exp_t e;
`ifdef DIV_SIGNED_EN
    int sa;
    int sv;
    sa = int'($signed(a));
    sv = int'($signed(b));
`endif
    e.t0 = t0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
      e.lat = 2;
    end else begin
      e.dbz = 1'b0;
`ifdef DIV_SIGNED_EN
      e.q   = W'(sa / sv);
      e.r   = W'(sa % sv);
      e.lat = 2 * W + 2;
`else
      e.q   = a / b;
      e.r   = a % b;
      e.lat = 2 * W + 1;
`endif
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (prev_done) chk("done_pulse", done, 0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", q, mon_e.q);
        chk("remainder", r, mon_e.r);
        chk("div_by_zero", dbz, mon_e.dbz);
        chk("busy_in_done", busy, 0);
        chk("latency", cyc - mon_e.t0, mon_e.lat);
      end
    end
    prev_done <= done;
  end

  // called at a negedge while the DUT is idle
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    dvd   = a;
    dvs   = b;
    start = 1'b1;
    sb.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ta[9];
    logic [W-1:0] tb[9];
    int n;
    ta = '{8'd100, 8'd255, 8'd3, 8'd37, 8'd10, 8'hF9, 8'd7, 8'h80, 8'd0};
    tb = '{8'd7, 8'd1, 8'd200, 8'd0, 8'd3, 8'd2, 8'hFE, 8'hFF, 8'd9};
    rst   = 1'b1;
    start = 1'b0;
    dvd   = '0;
    dvs   = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", q, 0);
    chk("rst_remainder", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      op(ta[i], tb[i]);
      wait_idle();
    end

    // start held through a whole operation yields a single result
    dvd   = 8'd50;
    dvs   = 8'd5;
    start = 1'b1;
    sb.push_back(model(8'd50, 8'd5, cyc + 1));
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("held_timeout", sb.size(), 0);
      sb.delete();
    end
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("held_start_idle", busy, 0);

    // start asserted during the done cycle is dropped
    op(8'd100, 8'd7);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("start_in_done_ignored", busy, 0);

    // reset sampled 6 edges after the start edge
    dvd   = 8'd200;
    dvs   = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_quotient", q, 0);
    chk("midrst_remainder", r, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_dbz", dbz, 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    op(8'd200, 8'd9);
    wait_idle();

    for (int i = 0; i < 20; i++) begin
      op(W'($urandom), (i % 7 == 3) ? '0 : W'($urandom));
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
